mem_cache_ctrl: RTL and testbench

//  MEM-stage cache controller: serves MEM_R_EN/MEM_W_EN accesses from the MEM pipeline stage

---
 rtl/mem_cache_ctrl_if.sv | 26 ++
 rtl/mem_cache_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cache_ctrl_if.sv
// Bundle between the MEM stage, the cache controller and the 64-bit SRAM port.
// The controller takes the slave modport; the pipeline/SRAM side takes master.
interface mem_cache_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        freeze;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata, sram_rdata, sram_ready,
    output rdata, freeze, sram_req, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output mem_r_en, mem_w_en, addr, wdata, sram_rdata, sram_ready,
    input  rdata, freeze, sram_req, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache for the MEM stage.
// One 64-bit line per set; loads hit in zero cycles, misses and stores freeze the pipe.
module mem_cache_ctrl #(
  parameter int INDEX_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_cache_ctrl_if.slave bus
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 32 - 3 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_mem [SETS];
  logic [1:0][31:0]   rd_word;

  logic [31:0]        sram_addr_q;
  logic [31:0]        wdata_q;
  logic               capture;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;

  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               hit_q;
  logic               fill_en;
  logic               upd_en;

  // Lookup for the request currently presented by the MEM stage.
  assign idx = bus.addr[2+INDEX_W:3];
  assign tag = bus.addr[31:3+INDEX_W];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  // Lookup for the transaction in flight, taken from the captured address.
  assign idx_q = sram_addr_q[2+INDEX_W:3];
  assign tag_q = sram_addr_q[31:3+INDEX_W];
  assign hit_q = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);

  assign fill_en = (state_q == RD_MISS) && bus.sram_ready;
  assign upd_en  = (state_q == WR) && bus.sram_ready && hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    bus.freeze = 1'b0;
    bus.rdata  = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.mem_w_en) begin
          state_d    = WR;
          capture    = 1'b1;
          bus.freeze = 1'b1;
        end else if (bus.mem_r_en) begin
          if (hit) begin
            bus.rdata = rd_word[bus.addr[2]];
          end else begin
            state_d    = RD_MISS;
            capture    = 1'b1;
            bus.freeze = 1'b1;
          end
        end
      end
      RD_MISS: begin
        if (bus.sram_ready) begin
          state_d   = IDLE;
          bus.rdata = sram_addr_q[2] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
        end else begin
          bus.freeze = 1'b1;
        end
      end
      WR: begin
        if (bus.sram_ready) begin
          state_d = IDLE;
        end else begin
          bus.freeze = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address and store data are frozen on leaving IDLE so the SRAM sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_q <= 32'h0;
      wdata_q     <= 32'h0;
    end else if (capture) begin
      sram_addr_q <= bus.addr & 32'hFFFF_FFFC;
      wdata_q     <= bus.wdata;
    end
  end

  assign bus.sram_req   = (state_q != IDLE);
  assign bus.sram_we    = (state_q == WR);
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx_q] <= tag_q;
    end
  end

  // Per-word data arrays: a refill writes both words, a store hit writes only its own word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_word
    logic [31:0] word_mem [SETS];

    always_ff @(posedge clk) begin
      if (fill_en) begin
        word_mem[idx_q] <= bus.sram_rdata[32*gi +: 32];
      end else if (upd_en && (sram_addr_q[2] == 1'(gi))) begin
        word_mem[idx_q] <= wdata_q;
      end
    end

    assign rd_word[gi] = word_mem[idx];
  end

  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.sram_req && !bus.sram_ready) |=> ($stable(bus.sram_addr) && $stable(bus.sram_wdata)));

  a_req_drop : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.sram_req && bus.sram_ready) |=> !bus.sram_req);

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed and randomized bench for mem_cache_ctrl; the bench plays both MEM stage and SRAM.
// Expectations come from a line-address cache model plus a sparse backing memory.
module tb_mem_cache_ctrl;
  localparam int INDEX_W = 6;
  localparam int SETS    = 1 << INDEX_W;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_cache_ctrl_if bus ();

  mem_cache_ctrl #(.INDEX_W(INDEX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which line (addr>>3) each set holds, and the contents of memory by line.
  bit          m_valid [SETS];
  bit [28:0]   m_line  [SETS];
  bit [63:0]   backing [bit [28:0]];

  function automatic bit [63:0] get_line(input bit [28:0] la);
    if (!backing.exists(la)) backing[la] = {$urandom, $urandom};
    return backing[la];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.mem_r_en   = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = 64'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the pipeline inputs released.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input int n);
    bit [28:0]  la;
    int         idx;
    bit         wsel;
    bit         is_hit;
    bit [63:0]  ln;
    la     = a[31:3];
    idx    = int'(la % SETS);
    wsel   = a[2];
    is_hit = m_valid[idx] && (m_line[idx] == la);

    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.addr     = a;
    bus.wdata    = wd;

    if (!r && !w) begin
      @(negedge clk);
      check("idle_freeze", bus.freeze, 0);
      check("idle_rdata", bus.rdata, 0);
      check("idle_req", bus.sram_req, 0);
      @(posedge clk); #1;
      return;
    end

    if (!w && is_hit) begin
      ln = get_line(la);
      @(negedge clk);
      check("hit_freeze", bus.freeze, 0);
      check("hit_rdata", bus.rdata, wsel ? ln[63:32] : ln[31:0]);
      check("hit_req", bus.sram_req, 0);
      @(posedge clk); #1;
      clear_inputs();
      return;
    end

    @(negedge clk);
    check("start_freeze", bus.freeze, 1);
    check("start_req", bus.sram_req, 0);
    @(posedge clk); #1;

    for (int k = 0; k < n; k++) begin
      bus.sram_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("wait_req", bus.sram_req, 1);
      check("wait_we", bus.sram_we, w);
      check("wait_addr", bus.sram_addr, a & 32'hFFFF_FFFC);
      if (w) check("wait_wdata", bus.sram_wdata, wd);
      check("wait_freeze", bus.freeze, 1);
      check("wait_rdata", bus.rdata, 0);
      @(posedge clk); #1;
    end

    bus.sram_ready = 1'b1;
    ln = get_line(la);
    bus.sram_rdata = w ? {$urandom, $urandom} : ln;
    @(negedge clk);
    check("done_freeze", bus.freeze, 0);
    check("done_req", bus.sram_req, 1);
    check("done_addr", bus.sram_addr, a & 32'hFFFF_FFFC);
    if (w) check("done_rdata", bus.rdata, 0);
    else   check("done_rdata", bus.rdata, wsel ? ln[63:32] : ln[31:0]);
    @(posedge clk); #1;
    clear_inputs();

    if (w) begin
      if (wsel) ln[63:32] = wd;
      else      ln[31:0]  = wd;
      backing[la] = ln;
    end else begin
      m_valid[idx] = 1'b1;
      m_line[idx]  = la;
    end

    @(negedge clk);
    check("gap_req", bus.sram_req, 0);
    check("gap_freeze", bus.freeze, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_freeze", bus.freeze, 0);
    check("rst_req", bus.sram_req, 0);
    check("rst_we", bus.sram_we, 0);
    check("rst_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: cold load miss with 3 wait cycles; 2: hit on other word
    backing[29'(32'h40 >> 3)] = {32'h0000_BBBB, 32'h0000_AAAA};
    access(1, 0, 32'h40, 32'h0, 3);
    access(1, 0, 32'h44, 32'h0, 0);

    // 3: store hit updates the cached word
    access(0, 1, 32'h44, 32'h1234, 2);
    access(1, 0, 32'h44, 32'h0, 0);

    // 4: conflicting tag evicts, original misses again
    access(1, 0, 32'h40 + (32'h1 << (3 + INDEX_W)), 32'h0, 1);
    access(1, 0, 32'h40, 32'h0, 1);

    // 5: reset in the middle of a read miss, then a stray ready
    bus.mem_r_en = 1'b1;
    bus.addr     = 32'h48;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", bus.sram_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("midrst_req", bus.sram_req, 0);
    check("midrst_freeze", bus.freeze, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    bus.sram_ready = 1'b1;
    bus.sram_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("late_ready_freeze", bus.freeze, 0);
    check("late_ready_req", bus.sram_req, 0);
    check("late_ready_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    clear_inputs();
    access(1, 0, 32'h40, 32'h0, 2);
    access(1, 0, 32'h48, 32'h0, 0);

    // 6: read and write together take the store path without filling
    access(1, 1, 32'h88, 32'hCAFE_0001, 1);
    access(1, 0, 32'h88, 32'h0, 0);
    access(1, 0, 32'h88, 32'h0, 0);

    // Top-of-memory address wraps through the normal slicing
    access(1, 0, 32'hFFFF_FFFC, 32'h0, 1);
    access(1, 0, 32'hFFFF_FFF8, 32'h0, 0);
    access(0, 1, 32'hFFFF_FFF8, 32'h5A5A_A5A5, 0);
    access(1, 0, 32'hFFFF_FFF8, 32'h0, 0);

    // Randomized mix over a few sets and tags to force hits, conflicts and store misses
    for (int it = 0; it < 250; it++) begin
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) begin
        a = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      end else begin
        a = (32'($urandom_range(0, 2)) << (3 + INDEX_W)) |
            (32'($urandom_range(0, 3)) << 3) |
            32'($urandom_range(0, 7));
      end
      case (op)
        0:       access(0, 0, a, 32'h0, 0);
        1, 2, 3,
        4, 5:    access(1, 0, a, 32'h0, int'($urandom_range(0, 4)));
        6, 7, 8: access(0, 1, a, $urandom, int'($urandom_range(0, 4)));
        default: access(1, 1, a, $urandom, int'($urandom_range(0, 4)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
